// File: rtl/ppc_fetch_unit.sv
// Fetch stage for the PPC execute core: fetches big-endian doublewords, splits them into
// instructions and queues {pc, inst} pairs. Vectors use [63:0], so PPC bit i is bit 63-i.
module ppc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirectPC,
    output logic        memReqValid,
    output logic [60:0] memReqAddr,
    input  logic        memReqReady,
    input  logic        memRespValid,
    input  logic [63:0] memRespData,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [63:0] instPC,
    input  logic        instReady
);

    localparam int unsigned PtrW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;
    typedef enum logic [1:0] {StIssue, StWait, StDrain} state_t;

    state_t      state;
    logic [63:0] fpc;
    ptr_t        head;
    ptr_t        tail;
    cnt_t        count;
    logic [31:0] q_inst [QDEPTH];
    logic [63:0] q_pc   [QDEPTH];

    logic req_fire;
    logic pop;
    logic push;
    logic push_two;
    cnt_t push_cnt;
    ptr_t tail_nx;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirectPC[1:0];

    always_comb begin
        // Reset gates the valids so nothing leaks out during the reset cycle itself.
        memReqValid = !reset && (state == StIssue) && (count <= cnt_t'(QDEPTH - 2));
        memReqAddr  = fpc[63:3];
        instValid   = !reset && (count != '0);
        inst        = q_inst[head];
        instPC      = q_pc[head];
        req_fire    = memReqValid && memReqReady;
        pop         = instValid && instReady;
        push        = (state == StWait) && memRespValid && !redirect;
        push_two    = !fpc[2];
        push_cnt    = push ? (push_two ? cnt_t'(2) : cnt_t'(1)) : '0;
        tail_nx     = tail + ptr_t'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc   <= RESET_PC & ~64'h3;
            state <= StIssue;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            fpc   <= {redirectPC[63:2], 2'b00};
            head  <= tail;
            count <= '0;
            case (state)
                StIssue: state <= req_fire ? StDrain : StIssue;
                // A response landing with the redirect still retires the outstanding request.
                StWait, StDrain: state <= memRespValid ? StIssue : StDrain;
                default: state <= StIssue;
            endcase
        end else begin
            case (state)
                StIssue: if (req_fire) state <= StWait;
                StWait: begin
                    if (memRespValid) begin
                        state <= StIssue;
                        fpc   <= {fpc[63:3] + 61'd1, 3'b000};
                        tail  <= tail + ptr_t'(push_cnt);
                    end
                end
                StDrain: if (memRespValid) state <= StIssue;
                default: state <= StIssue;
            endcase
            if (pop) head <= head + ptr_t'(1);
            count <= count + push_cnt - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail] <= fpc;
            if (push_two) begin
                q_inst[tail]    <= memRespData[63:32];
                q_pc[tail_nx]   <= fpc + 64'd4;
                q_inst[tail_nx] <= memRespData[31:0];
            end else begin
                q_inst[tail] <= memRespData[31:0];
            end
        end
    end

endmodule

// File: tb/tb_ppc_fetch_unit.sv
// Bench for ppc_fetch_unit: directed phases, a credit-limited memory model and a
// scoreboard monitor that checks every consumed instruction against the expected PC order.
module tb_ppc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [63:0] redirectPC;
    logic        memReqValid;
    logic [60:0] memReqAddr;
    logic        memReqReady;
    logic        memRespValid;
    logic [63:0] memRespData;
    logic        instValid;
    logic [31:0] inst;
    logic [63:0] instPC;
    logic        instReady;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];

    int          mem_lat = 1;
    int          mem_credit = 0;
    int          mem_wait = 0;
    logic        mem_pend = 1'b0;
    logic [60:0] mem_addr = '0;
    logic [60:0] last_acc_addr = '0;

    ppc_fetch_unit #(
        .RESET_PC(64'h0),
        .QDEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirectPC  (redirectPC),
        .memReqValid (memReqValid),
        .memReqAddr  (memReqAddr),
        .memReqReady (memReqReady),
        .memRespValid(memRespValid),
        .memRespData (memRespData),
        .instValid   (instValid),
        .inst        (inst),
        .instPC      (instPC),
        .instReady   (instReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h3C5A_0000;
    endfunction

    function automatic logic [63:0] mem_word(input logic [60:0] a);
        logic [63:0] p;
        p = {a, 3'b000};
        return {word_at(p), word_at(p + 64'd4)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #2;
            if (memReqValid && memReqReady) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: no request accepted within %0d cycles", name, bound);
    endtask

    task automatic wait_empty(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Memory model: one outstanding request, fixed latency, accepts while credit remains.
    initial begin
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespData  = '0;
        forever begin
            @(negedge clk);
            memReqReady  = (mem_credit != 0);
            memRespValid = 1'b0;
            if (mem_pend) begin
                if (mem_wait <= 1) begin
                    memRespValid = 1'b1;
                    memRespData  = mem_word(mem_addr);
                    mem_pend     = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            if (memReqValid && memReqReady) begin
                mem_pend      = 1'b1;
                mem_addr      = memReqAddr;
                last_acc_addr = memReqAddr;
                mem_wait      = mem_lat;
                mem_credit--;
            end
        end
    end

    // Scoreboard monitor: every consume must match the head of the expected stream.
    always @(negedge clk) begin
        if (instValid && instReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_inst: got pc %h inst %h, none expected", instPC, inst);
            end else begin
                logic [63:0] p;
                p = exp_q.pop_front();
                check("inst_pc", instPC, p);
                check("inst_word", {32'h0, inst}, {32'h0, word_at(p)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got hang, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset      = 1'b1;
        redirect   = 1'b0;
        redirectPC = '0;
        instReady  = 1'b1;
        mem_lat    = 1;
        mem_credit = 4;
        for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));

        // Reset and startup stream.
        tick();
        tick();
        @(negedge clk);
        check("reset_req_valid", {63'h0, memReqValid}, 64'd0);
        check("reset_inst_valid", {63'h0, instValid}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("first_req_valid", {63'h0, memReqValid}, 64'd1);
        check("first_req_addr", {3'b0, memReqAddr}, 64'h0);
        for (int k = 0; k < 20; k++) begin
            if (instValid) break;
            @(negedge clk);
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (instValid) cnt++;
            @(negedge clk);
        end
        check("steady_state_valid_cycles", 64'(cnt), 64'd8);
        wait_empty("startup_drained", 20);

        // Misaligned redirect: one entry from the upper word.
        tick();
        redirect   = 1'b1;
        redirectPC = 64'h106;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("misalign_req_addr", {3'b0, memReqAddr}, 64'h20);
        check("misalign_flush", {63'h0, instValid}, 64'd0);
        exp_q.push_back(64'h104);
        mem_credit = 1;
        wait_empty("misalign_drained", 20);
        repeat (3) tick();
        @(negedge clk);
        check("misalign_next_addr", {3'b0, memReqAddr}, 64'h21);
        check("misalign_next_valid", {63'h0, memReqValid}, 64'd1);

        // Backpressure: queue fills to 4, issue resumes at count 2.
        tick();
        instReady  = 1'b0;
        redirect   = 1'b1;
        redirectPC = 64'h200;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("bp_req_addr", {3'b0, memReqAddr}, 64'h40);
        for (int i = 0; i < 8; i++) exp_q.push_back(64'h200 + 64'(i * 4));
        mem_credit = 2;
        repeat (12) tick();
        @(negedge clk);
        check("bp_blocked", {63'h0, memReqValid}, 64'd0);
        check("bp_head_valid", {63'h0, instValid}, 64'd1);
        check("bp_accepts", 64'(mem_credit), 64'd0);
        tick();
        instReady = 1'b1;
        @(negedge clk);
        check("bp_count4_blocked", {63'h0, memReqValid}, 64'd0);
        tick();
        @(negedge clk);
        check("bp_count3_blocked", {63'h0, memReqValid}, 64'd0);
        tick();
        @(negedge clk);
        check("bp_count2_resume", {63'h0, memReqValid}, 64'd1);
        check("bp_resume_addr", {3'b0, memReqAddr}, 64'h42);
        mem_credit = 2;
        wait_empty("bp_drained", 40);

        // Redirect while waiting on a 3-cycle memory: stale response dropped.
        mem_lat    = 3;
        mem_credit = 1;
        wait_accept("wait_redirect_accept", 20);
        redirect   = 1'b1;
        redirectPC = 64'h300;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("drain_inst_valid", {63'h0, instValid}, 64'd0);
        check("drain_req_valid", {63'h0, memReqValid}, 64'd0);
        exp_q.push_back(64'h300);
        exp_q.push_back(64'h304);
        mem_credit = 1;
        wait_empty("drain_drained", 40);
        check("drain_refetch_addr", {3'b0, last_acc_addr}, 64'h60);

        // Redirect, response and pop in the same cycle.
        instReady = 1'b0;
        exp_q.push_back(64'h308);
        exp_q.push_back(64'h30C);
        mem_credit = 2;
        wait_accept("combo_accept1", 20);
        wait_accept("combo_accept2", 20);
        tick();
        tick();
        redirect   = 1'b1;
        redirectPC = 64'h400;
        instReady  = 1'b1;
        tick();
        redirect  = 1'b0;
        instReady = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("combo_flushed", {63'h0, instValid}, 64'd0);
        check("combo_req_valid", {63'h0, memReqValid}, 64'd1);
        check("combo_req_addr", {3'b0, memReqAddr}, 64'h80);
        repeat (4) tick();
        @(negedge clk);
        check("combo_resp_not_queued", {63'h0, instValid}, 64'd0);

        // Fetch PC wrap.
        tick();
        mem_lat    = 1;
        instReady  = 1'b1;
        redirect   = 1'b1;
        redirectPC = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_req_addr", {3'b0, memReqAddr}, 64'h1FFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        mem_credit = 1;
        wait_empty("wrap_drained", 20);
        @(negedge clk);
        check("wrap_next_addr", {3'b0, memReqAddr}, 64'h0);
        check("wrap_next_valid", {63'h0, memReqValid}, 64'd1);

        // Reset during WAIT; the late response must be ignored.
        tick();
        mem_lat    = 3;
        mem_credit = 1;
        wait_accept("rst_accept", 20);
        reset      = 1'b1;
        mem_credit = 0;
        @(negedge clk);
        check("rst_cycle_req_valid", {63'h0, memReqValid}, 64'd0);
        check("rst_cycle_inst_valid", {63'h0, instValid}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("rst_late_resp_delivered", {63'h0, mem_pend}, 64'd0);
        check("rst_late_resp_ignored", {63'h0, instValid}, 64'd0);
        check("rst_refetch_valid", {63'h0, memReqValid}, 64'd1);
        check("rst_refetch_addr", {3'b0, memReqAddr}, 64'h0);
        mem_lat = 1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        mem_credit = 1;
        wait_empty("rst_drained", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
